// File: rtl/cpu_io_pkg.sv
// -----------------------------------------------------------------------------
// cpu_io_pkg
// Shared constants for the memory-mapped CPU I/O peripherals on the 8-bit
// sysbus. It holds the peripheral addresses, the bit positions of the input
// port status byte, the command bits written to the status address, and a
// helper that packs the status byte.
// -----------------------------------------------------------------------------
package cpu_io_pkg;

    // Memory-mapped addresses (low WORD_W-OP_W bits of sysbus)
    localparam int DATA_ADDR    = 30;
    localparam int STAT_ADDR    = 29;
    localparam int DISPLAY_ADDR = 31;

    // Status byte bit positions
    localparam int STAT_NEMPTY  = 7;
    localparam int STAT_FULL    = 6;
    localparam int STAT_OVF     = 5;
    localparam int STAT_CNT_MSB = 4;
    localparam int STAT_CNT_W   = 5;

    // Command bits written to STAT_ADDR
    localparam int CMD_FLUSH    = 0;
    localparam int CMD_CLR_OVF  = 1;

    // Layout of the status byte as presented on the bus
    typedef struct packed {
        logic                  nempty;
        logic                  full;
        logic                  ovf;
        logic [STAT_CNT_W-1:0] count;
    } status_t;

    // Pack the flags and the zero-extended occupancy into one status byte
    function automatic logic [7:0] make_status(
        input logic                  nempty,
        input logic                  full,
        input logic                  ovf,
        input logic [STAT_CNT_W-1:0] count
    );
        status_t st;
        st.nempty = nempty;
        st.full   = full;
        st.ovf    = ovf;
        st.count  = count;
        return st;
    endfunction

endpackage : cpu_io_pkg

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Small synchronous FIFO. Push and pop may happen on the same edge. Flush
// empties the FIFO and takes priority over push and pop. Pushes while full and
// pops while empty are ignored, so the occupancy always stays in 0..DEPTH.
//
// Ports
//   clock  in   1        system clock
//   reset  in   1        synchronous, active-high
//   push   in   1        write wdata at the tail
//   pop    in   1        discard the head entry
//   flush  in   1        empty the FIFO (pointers and count to zero)
//   wdata  in   WORD_W   data to write
//   head   out  WORD_W   entry at the read pointer (undefined contents when empty)
//   full   out  1        count == DEPTH
//   empty  out  1        count == 0
//   count  out  CNT_W    current occupancy
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WORD_W = 8,
    parameter int DEPTH  = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] head,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WORD_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              push_ok_s;
    logic              pop_ok_s;

    // Guard the requests so the occupancy can never leave 0..DEPTH
    always_comb begin
        push_ok_s = push & ~full;
        pop_ok_s  = pop & ~empty;
    end

    assign full  = (count_r == CNT_FULL);
    assign empty = (count_r == {CNT_W{1'b0}});
    assign count = count_r;
    assign head  = mem_r[rd_ptr_r];

    // Storage array; only written on an accepted push, so no reset is needed
    always_ff @(posedge clock) begin
        if (push_ok_s && !flush && !reset) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of 2
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule : sync_fifo

// File: rtl/input_port.sv
// -----------------------------------------------------------------------------
// input_port
// Memory-mapped input peripheral on the shared sysbus. An external producer
// pushes bytes into a small FIFO over a valid/ready handshake. The CPU selects
// an address through MAR and then reads:
//   DATA_ADDR : FIFO head (0 when empty); the entry is popped when the read ends
//   STAT_ADDR : {!empty, full, ovf, count}
// Writing STAT_ADDR issues commands taken from MDR: bit0 flush, bit1 clear ovf.
//
// Ports
//   clock      in     1       system clock
//   reset      in     1       synchronous, active-high
//   sysbus     inout  WORD_W  shared bus, driven only during a decoded read
//   CS         in     1       chip select
//   load_MAR   in     1       capture sysbus address bits into mar
//   load_MDR   in     1       capture sysbus into mdr
//   R_NW       in     1       1 = CPU read, 0 = CPU write
//   in_data    in     WORD_W  producer byte
//   in_valid   in     1       producer has a byte
//   in_ready   out    1       port accepts a byte this cycle
//   data_avail out    1       FIFO not empty
// -----------------------------------------------------------------------------
module input_port #(
    parameter int WORD_W    = 8,
    parameter int OP_W      = 3,
    parameter int DEPTH     = 4,
    parameter int DATA_ADDR = cpu_io_pkg::DATA_ADDR,
    parameter int STAT_ADDR = cpu_io_pkg::STAT_ADDR
) (
    input  logic              clock,
    input  logic              reset,
    inout  wire  [WORD_W-1:0] sysbus,
    input  logic              CS,
    input  logic              load_MAR,
    input  logic              load_MDR,
    input  logic              R_NW,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              data_avail
);

    import cpu_io_pkg::*;

    localparam int ADDR_W = WORD_W - OP_W;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam logic [ADDR_W-1:0] DATA_A = ADDR_W'(DATA_ADDR);
    localparam logic [ADDR_W-1:0] STAT_A = ADDR_W'(STAT_ADDR);

    logic [ADDR_W-1:0] mar_r;
    logic [WORD_W-1:0] mdr_r;
    logic              rd_q_r;
    logic              ovf_r;

    logic              no_load_s;
    logic              rd_data_s;
    logic              rd_stat_s;
    logic              wr_cmd_s;
    logic              flush_s;
    logic              clr_ovf_s;
    logic              push_s;
    logic              pop_s;
    logic              drive_en_s;
    logic [WORD_W-1:0] drive_val_s;
    logic [WORD_W-1:0] status_s;

    logic [WORD_W-1:0] head_s;
    logic              full_s;
    logic              empty_s;
    logic [CNT_W-1:0]  count_s;

    logic              unused_mdr_s;

    // Only the two command bits of mdr are meaningful
    assign unused_mdr_s = ^mdr_r[WORD_W-1:2];

    // Address decode; a bus load cycle is never an access
    always_comb begin
        no_load_s = ~load_MAR & ~load_MDR;
        rd_data_s = CS & R_NW  & (mar_r == DATA_A) & no_load_s;
        rd_stat_s = CS & R_NW  & (mar_r == STAT_A) & no_load_s;
        wr_cmd_s  = CS & ~R_NW & (mar_r == STAT_A) & no_load_s;
        flush_s   = wr_cmd_s & mdr_r[CMD_FLUSH];
        clr_ovf_s = wr_cmd_s & mdr_r[CMD_CLR_OVF] & ~mdr_r[CMD_FLUSH];
    end

    // Handshake and FIFO control; a pop happens once, on the edge where a read ends
    always_comb begin
        in_ready = ~full_s & ~flush_s;
        push_s   = in_valid & in_ready;
        pop_s    = rd_q_r & ~rd_data_s & ~empty_s & ~flush_s;
    end

    assign data_avail = ~empty_s;

    // Status byte: flags plus zero-extended occupancy
    always_comb begin
        status_s = WORD_W'(make_status(~empty_s, full_s, ovf_r, STAT_CNT_W'(count_s)));
    end

    // Bus driver value; the head is masked to zero when the FIFO is empty
    always_comb begin
        drive_en_s = rd_data_s | rd_stat_s;
        if (rd_data_s) begin
            drive_val_s = empty_s ? {WORD_W{1'b0}} : head_s;
        end else if (rd_stat_s) begin
            drive_val_s = status_s;
        end else begin
            drive_val_s = {WORD_W{1'b0}};
        end
    end

    assign sysbus = drive_en_s ? drive_val_s : {WORD_W{1'bz}};

    // MAR/MDR capture with load_MAR taking priority over load_MDR
    always_ff @(posedge clock) begin
        if (reset) begin
            mar_r <= {ADDR_W{1'b0}};
            mdr_r <= {WORD_W{1'b0}};
        end else if (load_MAR) begin
            mar_r <= sysbus[ADDR_W-1:0];
            mdr_r <= mdr_r;
        end else if (load_MDR) begin
            mar_r <= mar_r;
            mdr_r <= sysbus;
        end else begin
            mar_r <= mar_r;
            mdr_r <= mdr_r;
        end
    end

    // Remember last cycle's data read so the falling end of a read can be detected
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_q_r <= 1'b0;
        end else begin
            rd_q_r <= rd_data_s;
        end
    end

    // Sticky overflow: a byte offered while not ready (a flush edge is not an overflow)
    always_ff @(posedge clock) begin
        if (reset) begin
            ovf_r <= 1'b0;
        end else if (in_valid && !in_ready && !flush_s) begin
            ovf_r <= 1'b1;
        end else if (clr_ovf_s) begin
            ovf_r <= 1'b0;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    sync_fifo #(
        .WORD_W (WORD_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clock  (clock),
        .reset  (reset),
        .push   (push_s),
        .pop    (pop_s),
        .flush  (flush_s),
        .wdata  (in_data),
        .head   (head_s),
        .full   (full_s),
        .empty  (empty_s),
        .count  (count_s)
    );

endmodule : input_port
